// File: rtl/bitmap_encoder_pkg.sv
// Shared types, default sizes and the popcount helper for the bitmap encoder.
// WIDTH may be at most 16, so a 5-bit count always fits.
package bitmap_enc_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int CODE_W_DEF = $clog2(WIDTH_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  function automatic logic [4:0] popcount(input logic [15:0] vec);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/bitmap_encoder_if.sv
// Bitmap input handshake and code output handshake, grouped as one bundle.
interface bitmap_encoder_if #(
  parameter int WIDTH  = 8,
  parameter int CODE_W = $clog2(WIDTH)
);

  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_ready;
  logic              out_valid;
  logic [CODE_W-1:0] out_code;
  logic              out_last;
  logic              out_ready;
  logic [CODE_W:0]   out_remain;
  logic              zero_pulse;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_code, out_last, out_remain, zero_pulse
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_code, out_last, out_remain, zero_pulse
  );

endinterface

// File: rtl/bitmap_encoder_lsb_finder.sv
// Combinational lowest-set-bit locator: returns the bit index and a one-hot
// mask of that bit, which the encoder uses to retire the code just sent.
module lsb_finder #(
  parameter int WIDTH  = 8,
  parameter int CODE_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]  vec_i,
  output logic [CODE_W-1:0] idx_o,
  output logic [WIDTH-1:0]  mask_o
);

  logic [WIDTH-1:0] mask_s;

  // Two's-complement trick isolates the lowest set bit.
  assign mask_s = vec_i & (~vec_i + {{(WIDTH-1){1'b0}}, 1'b1});
  assign mask_o = mask_s;

  always_comb begin
    idx_o = {CODE_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      idx_o = idx_o | (mask_s[i] ? CODE_W'(i) : {CODE_W{1'b0}});
    end
  end

endmodule

// File: rtl/bitmap_encoder.sv
// Sequential multi-hot to binary encoder: latches a bitmap, then emits the
// index of each set bit lowest-first, one per accepted output handshake.
module bitmap_encoder
  import bitmap_enc_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int CODE_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  bitmap_encoder_if.slave  bus
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  pend_q, pend_d;
  logic              zero_q, zero_d;

  logic [CODE_W-1:0] idx_s;
  logic [WIDTH-1:0]  clr_mask_s;
  logic [4:0]        cnt_s;
  logic              valid_s;
  logic              last_s;

  lsb_finder #(
    .WIDTH  (WIDTH),
    .CODE_W (CODE_W)
  ) u_lsb_finder (
    .vec_i  (pend_q),
    .idx_o  (idx_s),
    .mask_o (clr_mask_s)
  );

  assign cnt_s   = popcount(16'(pend_q));
  assign valid_s = (state_q == EMIT);
  assign last_s  = (cnt_s == 5'd1);

  // State, pending bitmap and zero-load flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= {WIDTH{1'b0}};
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state logic: load in IDLE, retire one bit per transfer in EMIT.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zero_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_data != {WIDTH{1'b0}}) begin
            pend_d  = bus.in_data;
            state_d = EMIT;
          end else begin
            zero_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          pend_d = pend_q & ~clr_mask_s;
          if (last_s) begin
            state_d = IDLE;
          end else begin
            state_d = EMIT;
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = {WIDTH{1'b0}};
      end
    endcase
  end

  // Outputs depend only on registered state; codes read zero when not valid.
  always_comb begin
    bus.in_ready   = ~valid_s;
    bus.out_valid  = valid_s;
    bus.zero_pulse = zero_q;
    if (valid_s) begin
      bus.out_code   = idx_s;
      bus.out_remain = cnt_s[CODE_W:0];
      bus.out_last   = last_s;
    end else begin
      bus.out_code   = {CODE_W{1'b0}};
      bus.out_remain = {(CODE_W+1){1'b0}};
      bus.out_last   = 1'b0;
    end
  end

endmodule

// File: tb/tb_bitmap_encoder.sv
// Self-checking bench for bitmap_encoder against a set-bit-list reference model.
module tb_bitmap_encoder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bitmap_encoder_if #(.WIDTH(8)) bus ();

  bitmap_encoder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_code !== 3'd0 ||
        bus.out_remain !== 4'd0 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: in_ready=%0b valid=%0b code=%0d remain=%0d last=%0b, want 1 0 0 0 0",
               tag, bus.in_ready, bus.out_valid, bus.out_code, bus.out_remain, bus.out_last);
    end
  endtask

  task automatic load(input logic [7:0] bm);
    bus.in_valid = 1'b1;
    bus.in_data  = bm;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Reference: list of set-bit indices, consumed front-first on each transfer.
  task automatic emit_and_check(input logic [7:0] bm, input bit rand_ready, input string tag);
    int q[$];
    int guard;
    for (int i = 0; i < 8; i++) begin
      if (bm[i]) q.push_back(i);
    end
    guard = 0;
    while (q.size() > 0 && guard < 64) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_code !== 3'(q[0]) || bus.out_remain !== 4'(q.size()) ||
          bus.out_last !== (q.size() == 1) || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s emit: valid=%0b code=%0d remain=%0d last=%0b in_ready=%0b, want 1 %0d %0d %0b 0",
                 tag, bus.out_valid, bus.out_code, bus.out_remain, bus.out_last, bus.in_ready,
                 q[0], q.size(), (q.size() == 1));
      end
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      if (bus.out_ready) void'(q.pop_front());
      guard++;
    end
    if (guard >= 64) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: %0d codes still pending, want 0", tag, q.size());
    end
    bus.out_ready = 1'b1;
    check_idle(tag);
  endtask

  task automatic test_reset();
    step();
    load(8'b0011_0000);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_code !== 3'd0 ||
        bus.out_remain !== 4'd0 || bus.zero_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%0b valid=%0b code=%0d remain=%0d zero=%0b, want 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_code, bus.out_remain, bus.zero_pulse);
    end
    step();
    rst_n = 1'b1;
    step();
    check_idle("post_reset");
  endtask

  task automatic test_basic();
    load(8'b1010_0100);
    emit_and_check(8'b1010_0100, 1'b0, "basic");
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    load(8'b1000_0001);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_code !== 3'd0 || bus.out_remain !== 4'd2 ||
          bus.out_last !== 1'b0) begin
        errors++;
        $display("FAIL backpressure hold%0d: valid=%0b code=%0d remain=%0d last=%0b, want 1 0 2 0",
                 c, bus.out_valid, bus.out_code, bus.out_remain, bus.out_last);
      end
      step();
    end
    emit_and_check(8'b1000_0001, 1'b0, "backpressure");
  endtask

  task automatic test_zero();
    load(8'h00);
    checks++;
    if (bus.zero_pulse !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero load: zero=%0b valid=%0b in_ready=%0b, want 1 0 1",
               bus.zero_pulse, bus.out_valid, bus.in_ready);
    end
    step();
    checks++;
    if (bus.zero_pulse !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero after: zero=%0b valid=%0b, want 0 0", bus.zero_pulse, bus.out_valid);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (bus.zero_pulse !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL zero b2b%0d: zero=%0b in_ready=%0b valid=%0b, want 1 1 0",
                 c, bus.zero_pulse, bus.in_ready, bus.out_valid);
      end
    end
    bus.in_valid = 1'b0;
    step();
    check_idle("zero_end");
  endtask

  task automatic test_full();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    step();
    bus.in_data  = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_code !== 3'(i) || bus.out_remain !== 4'(8 - i) ||
          bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL full code%0d: valid=%0b code=%0d remain=%0d in_ready=%0b, want 1 %0d %0d 0",
                 i, bus.out_valid, bus.out_code, bus.out_remain, bus.in_ready, i, 8 - i);
      end
      step();
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full done: in_ready=%0b valid=%0b, want 1 0", bus.in_ready, bus.out_valid);
    end
    step();
    bus.in_valid = 1'b0;
    emit_and_check(8'h0F, 1'b0, "full_next");
  endtask

  task automatic test_reset_emit();
    load(8'b0011_1100);
    step();
    checks++;
    if (bus.out_code !== 3'd3 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_emit pre: code=%0d valid=%0b, want 3 1", bus.out_code, bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_remain !== 4'd0) begin
      errors++;
      $display("FAIL rst_emit async: valid=%0b in_ready=%0b remain=%0d, want 0 1 0",
               bus.out_valid, bus.in_ready, bus.out_remain);
    end
    step();
    rst_n = 1'b1;
    step();
    load(8'b0000_0010);
    emit_and_check(8'b0000_0010, 1'b0, "rst_emit_next");
  endtask

  task automatic test_random();
    logic [7:0] bm;
    for (int n = 0; n < 25; n++) begin
      bm = 8'($urandom_range(0, 255));
      load(bm);
      if (bm == 8'h00) begin
        checks++;
        if (bus.zero_pulse !== 1'b1 || bus.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL random zero: zero=%0b valid=%0b, want 1 0", bus.zero_pulse, bus.out_valid);
        end
        step();
      end else begin
        emit_and_check(bm, 1'b1, "random");
      end
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    #1;
    check_idle("initial_reset");
    step();
    rst_n = 1'b1;
    step();
    test_basic();
    test_backpressure();
    test_zero();
    test_full();
    test_reset();
    test_reset_emit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitmap_encoder.md
# bitmap_encoder

Sequential 8-to-3 encoder that converts a multi-hot bitmap back into a stream of binary codes. It is the inverse of the positional decoder: a bitmap is latched with a valid/ready handshake. The block then emits the index of every set bit, lowest index first, one code per accepted output handshake, and flags the last code of each bitmap. It sits between status and request collectors and any consumer that takes binary indices.

## Interface
Parameters:
- WIDTH, 8, bitmap width; power of two, 2..16
- CODE_W, $clog2(WIDTH) (3 at default), output code width; derived, not overridden

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  bitmap offered
- in_data  in  WIDTH  multi-hot bitmap
- in_ready  out  1  block can accept a bitmap (high only in IDLE)
- out_valid  out  1  out_code is valid
- out_code  out  CODE_W  index of the lowest pending set bit
- out_last  out  1  current code is the final one for this bitmap
- out_ready  in  1  consumer accepts the current code
- out_remain  out  CODE_W+1  number of pending set bits, including the current one
- zero_pulse  out  1  one-cycle flag: an all-zero bitmap was accepted

## Operation
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- State: the block has a two-state FSM, IDLE and EMIT, and a pending register pend_q[WIDTH-1:0].
- Reset values: state=IDLE, pend_q=0, in_ready=1, out_valid=0, out_code=0, out_last=0, out_remain=0, zero_pulse=0.
- IDLE behaviour:
  - in_ready=1.
  - On in_valid with in_data≠0: pend_q<=in_data and state moves to EMIT.
  - On in_valid with in_data=0: stay in IDLE; zero_pulse=1 for exactly the next cycle; no code is emitted.
- EMIT behaviour:
  - out_valid=1 and in_ready=0.
  - out_code = index of the lowest set bit of pend_q.
  - out_remain = popcount(pend_q).
  - out_last = (out_remain==1).
- Output handshake: a transfer happens when out_valid && out_ready. On a transfer:
  - The lowest set bit is cleared in pend_q.
  - If out_last=1, state returns to IDLE.
- Input ignored in EMIT: in_valid and in_data are ignored while in EMIT; there is no bitmap queueing and no same-cycle reload.
- Output path: out_code, out_last and out_remain are decoded from pend_q only. There is no combinational path from any input to any output.
- Idle outputs: out_code, out_last and out_remain read 0 whenever out_valid=0.

## Timing
- Latency: input handshake at edge N gives out_valid=1 during cycle N+1.
- Throughput: one code per cycle when out_ready is held high.
- Bitmap cycle count: a bitmap with k set bits occupies 1+k cycles from load to in_ready returning high.
- Return to IDLE: in_ready rises in the cycle after the last handshake.
- Backpressure: while out_valid && !out_ready, out_code, out_last and out_remain hold stable. out_valid never drops without a transfer, except on reset.
- Zero bitmap: an all-zero load returns zero_pulse=1 for one cycle. in_ready stays 1 throughout, so back-to-back zero loads are accepted every cycle.
- Reset during EMIT: asserting rst_n low clears pend_q and drops out_valid immediately, without waiting for an edge. The pending codes are lost. After release the block is in IDLE.
- Simultaneous events: in_valid arriving in the same cycle as the final output handshake is not accepted, because in_ready=0 in that cycle.

## Structure
- Package bitmap_enc_pkg holds:
  - the state enum {IDLE, EMIT}
  - the WIDTH/CODE_W default constants
  - a popcount function
- Sub-module lsb_finder: a parameterised combinational block.
  - Input: pend_q.
  - Outputs: lowest-set-bit index and a one-hot clear mask.
  - It is instantiated once.
- Top level contains the FSM, pend_q and the output registers and decode.

## Test plan
- Reset: assert rst_n=0 mid-simulation. Outputs must be in_ready=1, out_valid=0, out_code=0, out_remain=0, zero_pulse=0.
- Basic bitmap: load 8'b1010_0100 with out_ready=1.
  - Codes 2, 5, 7 appear on three consecutive cycles.
  - out_remain reads 3, 2, 1.
  - out_last is high only with code 7.
  - in_ready=1 on the following cycle.
- Backpressure: load 8'b1000_0001 and hold out_ready=0 for 3 cycles.
  - Code 0 is held stable with out_remain=2.
  - After release the block emits 0, then 7 with out_last.
- Zero bitmap: load 8'h00. zero_pulse is high for 1 cycle, out_valid never rises, and in_ready stays high.
- Full bitmap: load 8'hFF with in_valid held high throughout.
  - Codes 0..7 are emitted in 8 cycles.
  - No reload happens during EMIT.
  - The next bitmap is accepted at the first cycle with in_ready=1.
- Reset during EMIT: pulse rst_n low after code 2 of 8'b0011_1100 (i.e. while code 3 is the current output).
  - out_valid drops asynchronously.
  - A subsequent load of 8'b0000_0010 emits only code 1 with out_last.
